mc_data_path: RTL

//  Multicycle ARM-subset datapath with built-in sequencer; replaces the single-cycle datapath.

---
 rtl/mc_pkg.sv | 69 ++++++
 rtl/mc_reg_file.sv | 37 +++
 rtl/mc_data_path.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and helpers for the multicycle ARM-subset datapath.
package mc_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  // Major opcodes, instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // ALU commands, instr[24:21]; anything else behaves as AND
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;

  // Evaluate a condition field against NZCV (bit 3 = N ... bit 0 = V).
  // The unused encoding 4'hF is treated as always-pass.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mc_reg_file.sv
// r0..r14 register file: two combinational read ports, one write port.
// Address 15 reads back the supplied r15 value and is never written.
module mc_reg_file
  import mc_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  ra1_i,
  input  logic [3:0]  ra2_i,
  input  logic        we_i,
  input  logic [3:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] r15_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [0:14];

  // Storage clears on reset; writes to index 15 are dropped
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != 4'd15)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Reads see the stored value, so a same-cycle write returns the old data
  always_comb begin
    rd1_o = (ra1_i == 4'd15) ? r15_i : regs_q[ra1_i];
    rd2_o = (ra2_i == 4'd15) ? r15_i : regs_q[ra2_i];
  end

endmodule

// File: rtl/mc_data_path.sv
// Multicycle ARM-subset datapath with its own sequencer and a single shared
// memory port for instruction fetch and load/store.
module mc_data_path
  import mc_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          COND_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pc,
  output logic [3:0]        flags,
  output logic              illegal,
  output logic              retire
);

  state_t              state_q;
  logic [31:0]         pc_q;
  logic [31:0]         ir_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic [31:0]         result_q;
  logic [3:0]          flags_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                retire_q;
  logic                illegal_q;

  // Instruction fields
  logic [3:0]  cond_f;
  logic [1:0]  op_f;
  logic        imm_f;
  logic [3:0]  cmd_f;
  logic        s_f;
  logic        u_f;
  logic [3:0]  rn_f;
  logic [3:0]  rd_f;
  logic [3:0]  rm_f;

  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic        rf_we_d;
  logic        cond_ok_d;
  logic [31:0] src_b_d;
  logic [31:0] imm12_d;
  logic [31:0] br_off_d;
  logic [31:0] br_target_d;
  logic [31:0] mem_addr_d;
  logic [32:0] alu_sum_d;
  logic [31:0] alu_res_d;
  logic        alu_c_d;
  logic        alu_v_d;
  logic [3:0]  alu_flags_d;

  assign cond_f = ir_q[31:28];
  assign op_f   = ir_q[27:26];
  assign imm_f  = ir_q[25];
  assign cmd_f  = ir_q[24:21];
  assign s_f    = ir_q[20];
  assign u_f    = ir_q[23];
  assign rn_f   = ir_q[19:16];
  assign rd_f   = ir_q[15:12];
  assign rm_f   = ir_q[3:0];

  // Stores read their data from Rd; everything else reads Rm on port 2
  mc_reg_file u_rf (
    .clk_i   (clk),
    .reset_i (reset),
    .ra1_i   (rn_f),
    .ra2_i   ((op_f == OP_MEM) ? rd_f : rm_f),
    .we_i    (rf_we_d),
    .wa_i    (rd_f),
    .wd_i    (result_q),
    .r15_i   (pc_q + 32'd4),
    .rd1_o   (rd1_d),
    .rd2_o   (rd2_d)
  );

  assign rf_we_d = (state_q == WB) && (rd_f != 4'd15);

  // Operand extension, branch target, load/store address and condition check
  always_comb begin
    src_b_d     = imm_f ? {24'd0, ir_q[7:0]} : b_q;
    imm12_d     = {20'd0, ir_q[11:0]};
    br_off_d    = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
    br_target_d = pc_q + 32'd4 + br_off_d;
    mem_addr_d  = u_f ? (a_q + imm12_d) : (a_q - imm12_d);
    cond_ok_d   = (COND_EN == 0) ? 1'b1 : cond_pass(cond_f, flags_q);
  end

  // ALU: C and V only change on ADD/SUB, logical ops carry the old C/V through
  always_comb begin
    alu_sum_d = '0;
    alu_res_d = a_q & src_b_d;
    alu_c_d   = flags_q[1];
    alu_v_d   = flags_q[0];
    case (cmd_f)
      ALU_ADD: begin
        alu_sum_d = {1'b0, a_q} + {1'b0, src_b_d};
        alu_res_d = alu_sum_d[31:0];
        alu_c_d   = alu_sum_d[32];
        alu_v_d   = (a_q[31] == src_b_d[31]) && (alu_res_d[31] != a_q[31]);
      end
      ALU_SUB: begin
        alu_sum_d = {1'b0, a_q} + {1'b0, ~src_b_d} + 33'd1;
        alu_res_d = alu_sum_d[31:0];
        alu_c_d   = alu_sum_d[32];
        alu_v_d   = (a_q[31] != src_b_d[31]) && (alu_res_d[31] != a_q[31]);
      end
      ALU_ORR: alu_res_d = a_q | src_b_d;
      default: alu_res_d = a_q & src_b_d;
    endcase
    alu_flags_d = {alu_res_d[31], (alu_res_d == 32'd0), alu_c_d, alu_v_d};
  end

  // Sequencer: every output is registered; leaving a completing state
  // pre-loads the next fetch request so FETCH can finish in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (!mem_req_q) begin
            // first cycle out of reset: raise the request
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q[ADDR_W-1:0];
          end else if (mem_ready) begin
            ir_q      <= mem_rdata;
            pc_q      <= pc_q + 32'd4;
            mem_req_q <= 1'b0;
            state_q   <= DECODE;
          end
        end
        DECODE: begin
          a_q     <= rd1_d;
          b_q     <= rd2_d;
          state_q <= EXEC;
        end
        EXEC: begin
          if (!cond_ok_d) begin
            retire_q   <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q[ADDR_W-1:0];
            state_q    <= FETCH;
          end else begin
            case (op_f)
              OP_DP: begin
                result_q <= alu_res_d;
                if (s_f) flags_q <= alu_flags_d;
                state_q <= WB;
              end
              OP_MEM: begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= !s_f;
                mem_addr_q  <= mem_addr_d[ADDR_W-1:0];
                mem_wdata_q <= s_f ? 32'd0 : b_q;
                state_q     <= MEM;
              end
              OP_B: begin
                pc_q       <= br_target_d;
                retire_q   <= 1'b1;
                mem_req_q  <= 1'b1;
                mem_addr_q <= br_target_d[ADDR_W-1:0];
                state_q    <= FETCH;
              end
              default: begin
                illegal_q  <= 1'b1;
                retire_q   <= 1'b1;
                mem_req_q  <= 1'b1;
                mem_addr_q <= pc_q[ADDR_W-1:0];
                state_q    <= FETCH;
              end
            endcase
          end
        end
        MEM: begin
          if (mem_ready) begin
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if (s_f) begin
              result_q  <= mem_rdata;
              mem_req_q <= 1'b0;
              state_q   <= WB;
            end else begin
              retire_q   <= 1'b1;
              mem_addr_q <= pc_q[ADDR_W-1:0];
              state_q    <= FETCH;
            end
          end
        end
        WB: begin
          retire_q  <= 1'b1;
          mem_req_q <= 1'b1;
          state_q   <= FETCH;
          if (rd_f == 4'd15) begin
            pc_q       <= result_q;
            mem_addr_q <= result_q[ADDR_W-1:0];
          end else begin
            mem_addr_q <= pc_q[ADDR_W-1:0];
          end
        end
        default: begin
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q[ADDR_W-1:0];
          state_q    <= FETCH;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;
  assign retire    = retire_q;

endmodule
